// File: rtl/CONFIG.sv
// CONFIG: shared audio clocking constants and sample types.
// The I2S bit-clock divider is derived from master clock and rate.
package CONFIG;

    localparam int AUDIO_CLOCK       = 16_934_400;
    localparam int AUDIO_SAMPLE_RATE = 44_100;
    localparam int AUDIO_BIT_WIDTH   = 24;

    localparam int I2S_SLOT_WIDTH    = 32;
    localparam int I2S_MCLK_PER_BCLK =
        AUDIO_CLOCK / (AUDIO_SAMPLE_RATE * 2 * I2S_SLOT_WIDTH);

    typedef struct packed {
        logic [AUDIO_BIT_WIDTH-1:0] left;
        logic [AUDIO_BIT_WIDTH-1:0] right;
    } audio_frame_t;

endpackage

// File: rtl/i2s_frame_timer.sv
// i2s_frame_timer: master-clock divider and bit counter for one
// I2S frame; drives BCLK/LRCLK and the bit/frame strobes.
module i2s_frame_timer #(
    parameter int  SLOT_WIDTH    = 32,
    parameter int  MCLK_PER_BCLK = 6,
    localparam int BW            = $clog2(2 * SLOT_WIDTH)
) (
    input  logic          clock_16_934_400,
    input  logic          reset_l,
    output logic          bclk_fall,
    output logic          bclk,
    output logic          lrclk,
    output logic          frame_tick,
    output logic [BW-1:0] slot_bit
);

    localparam int DW = $clog2(MCLK_PER_BCLK);

    localparam logic [DW-1:0] DIV_MAX  = DW'(MCLK_PER_BCLK - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_PER_BCLK / 2);
    localparam logic [BW-1:0] BIT_MAX  = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(SLOT_WIDTH);

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;

    // bclk_fall marks the last cycle of a BCLK period
    always_comb begin
        bclk_fall  = (div == DIV_MAX);
        frame_tick = bclk_fall && (bit_cnt == BIT_MAX);
        div_nxt    = bclk_fall ? '0 : div + 1'b1;
        bit_nxt    = bit_cnt;
        if (bclk_fall) begin
            bit_nxt = frame_tick ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            div     <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
        end else begin
            div     <= div_nxt;
            bit_cnt <= bit_nxt;
            bclk    <= (div_nxt >= DIV_HALF);
            lrclk   <= (bit_nxt >= BIT_HALF);
        end
    end

    assign slot_bit = bit_cnt;

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: single-entry sample holding register feeding a
// Philips I2S serialiser. Define I2S_UNDERRUN_HOLD_EN to repeat the
// last pair on underrun instead of sending silence.
module i2s_transmitter
    import CONFIG::*;
#(
    parameter int SAMPLE_WIDTH  = AUDIO_BIT_WIDTH,
    parameter int SLOT_WIDTH    = I2S_SLOT_WIDTH,
    parameter int MCLK_PER_BCLK = I2S_MCLK_PER_BCLK
) (
    input  logic                    clock_16_934_400,
    input  logic                    reset_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    sample_request,
    output logic                    underrun,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata
);

    localparam int FRAME_W = 2 * SLOT_WIDTH;
    localparam int BW      = $clog2(FRAME_W);
    localparam int PAD     = SLOT_WIDTH - 1 - SAMPLE_WIDTH;

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] left;
        logic [SAMPLE_WIDTH-1:0] right;
    } pair_t;

    logic               bclk_fall;
    logic               frame_tick;
    logic [BW-1:0]      slot_bit;
    logic [BW-1:0]      sdata_idx;
    logic               ready_q;
    logic               sdata_q;
    logic               request_q;
    logic               underrun_q;
    logic               accept;
    pair_t              held;
    logic [FRAME_W-1:0] tx_frame;
    logic [FRAME_W-1:0] frame_nxt;

    // One idle bit after the LRCLK edge, then MSB-first, zero padded
    function automatic logic [SLOT_WIDTH-1:0] to_slot(
        input logic [SAMPLE_WIDTH-1:0] s
    );
        return {{(SLOT_WIDTH - SAMPLE_WIDTH){1'b0}}, s} << PAD;
    endfunction

    i2s_frame_timer #(
        .SLOT_WIDTH    (SLOT_WIDTH),
        .MCLK_PER_BCLK (MCLK_PER_BCLK)
    ) u_timer (
        .clock_16_934_400 (clock_16_934_400),
        .reset_l          (reset_l),
        .bclk_fall        (bclk_fall),
        .bclk             (i2s_bclk),
        .lrclk            (i2s_lrclk),
        .frame_tick       (frame_tick),
        .slot_bit         (slot_bit)
    );

    always_comb begin
        accept = sample_valid && ready_q;
`ifdef I2S_UNDERRUN_HOLD_EN
        frame_nxt = tx_frame;
`else
        frame_nxt = '0;
`endif
        if (!ready_q) begin
            frame_nxt = {to_slot(held.left), to_slot(held.right)};
        end
        // bit k+1 of the frame, counted from the MSB
        sdata_idx = BW'(FRAME_W - 2) - slot_bit;
    end

    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            ready_q    <= 1'b1;
            held       <= '0;
            tx_frame   <= '0;
            sdata_q    <= 1'b0;
            request_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            request_q  <= frame_tick;
            underrun_q <= frame_tick && ready_q;
            if (frame_tick) begin
                tx_frame <= frame_nxt;
                sdata_q  <= frame_nxt[FRAME_W-1];
            end else if (bclk_fall) begin
                sdata_q  <= tx_frame[sdata_idx];
            end
            if (frame_tick && !ready_q) begin
                ready_q <= 1'b1;
            end else if (accept) begin
                ready_q    <= 1'b0;
                held.left  <= sample_left;
                held.right <= sample_right;
            end
        end
    end

    assign sample_ready   = ready_q;
    assign sample_request = request_q;
    assign underrun       = underrun_q;
    assign i2s_sdata      = sdata_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Randomized bench for i2s_transmitter against a frame-level model.
// Define I2S_UNDERRUN_HOLD_EN for bench and DUT to cover hold mode.
module tb_i2s_transmitter;
    import CONFIG::*;

    localparam int SW    = AUDIO_BIT_WIDTH;
    localparam int FRAME = 384;
    localparam int EAGER = 0;
    localparam int IDLE  = 1;
    localparam int RAND  = 2;
    localparam int LATE  = 3;

    logic          clock_16_934_400 = 1'b0;
    logic          reset_l          = 1'b0;
    logic [SW-1:0] sample_left      = '0;
    logic [SW-1:0] sample_right     = '0;
    logic          sample_valid     = 1'b0;
    logic          sample_ready;
    logic          sample_request;
    logic          underrun;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic         m_full = 1'b0;
    logic         m_und  = 1'b0;
    logic         busy   = 1'b0;
    audio_frame_t m_pend = '0;
    audio_frame_t m_tx   = '0;
    audio_frame_t pushq[$];

    always #5 clock_16_934_400 = ~clock_16_934_400;

    i2s_transmitter dut (
        .clock_16_934_400 (clock_16_934_400),
        .reset_l          (reset_l),
        .sample_left      (sample_left),
        .sample_right     (sample_right),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .sample_request   (sample_request),
        .underrun         (underrun),
        .i2s_bclk         (i2s_bclk),
        .i2s_lrclk        (i2s_lrclk),
        .i2s_sdata        (i2s_sdata)
    );

    task automatic check(input string tag, input logic got,
                         input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b",
                     tag, cyc, got, exp);
        end
    endtask

    // Philips slot: idle bit, 24 data bits MSB first, then zeros
    function automatic logic exp_bit(input audio_frame_t pr,
                                     input int k);
        int        j;
        logic [SW-1:0] s;
        j = k % 32;
        s = (k < 32) ? pr.left : pr.right;
        if (j >= 1 && j <= SW) return s[SW-j];
        return 1'b0;
    endfunction

    function automatic int mode_of(input int phase, input int f);
        if (phase == 1) begin
            case (f)
                0:       return IDLE;
                1:       return EAGER;
                default: return RAND;
            endcase
        end
        case (f)
            0, 5, 10: return EAGER;
            1, 2, 7:  return IDLE;
            3, 9:     return LATE;
            default:  return RAND;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_bclk"},     i2s_bclk,       1'b0);
        check({tag, "_lrclk"},    i2s_lrclk,      1'b0);
        check({tag, "_sdata"},    i2s_sdata,      1'b0);
        check({tag, "_request"},  sample_request, 1'b0);
        check({tag, "_underrun"}, underrun,       1'b0);
        check({tag, "_ready"},    sample_ready,   1'b1);
    endtask

    task automatic step(input int phase);
        int           p;
        logic         want;
        logic         acc;
        audio_frame_t item;
        p = cyc % FRAME;
        check("bclk",     i2s_bclk,       (p % 6) >= 3);
        check("lrclk",    i2s_lrclk,      (p / 6) >= 32);
        check("sdata",    i2s_sdata,      exp_bit(m_tx, p / 6));
        check("request",  sample_request, (p == 0) && (cyc > 0));
        check("underrun", underrun,       m_und);
        check("ready",    sample_ready,   !m_full);
        if (!busy) begin
            case (mode_of(phase, cyc / FRAME))
                EAGER:   want = 1'b1;
                IDLE:    want = 1'b0;
                RAND:    want = ($urandom_range(0, 99) < 2);
                default: want = (p == FRAME - 1);
            endcase
            if (want) begin
                if (pushq.size() == 0) begin
                    item.left  = SW'($urandom());
                    item.right = SW'($urandom());
                    pushq.push_back(item);
                end
                busy         = 1'b1;
                sample_left  = pushq[0].left;
                sample_right = pushq[0].right;
                sample_valid = 1'b1;
            end else begin
                sample_valid = 1'b0;
                sample_left  = SW'($urandom());
                sample_right = SW'($urandom());
            end
        end
        acc = sample_valid && !m_full;
        @(posedge clock_16_934_400);
        m_und = 1'b0;
        if (p == FRAME - 1) begin
            if (m_full) begin
                m_tx   = m_pend;
                m_full = 1'b0;
            end else begin
                m_und = 1'b1;
`ifndef I2S_UNDERRUN_HOLD_EN
                m_tx  = '0;
`endif
            end
        end
        if (acc) begin
            m_full = 1'b1;
            m_pend = pushq.pop_front();
            busy   = 1'b0;
        end
        cyc++;
        @(negedge clock_16_934_400);
    endtask

    initial begin
        pushq.push_back(audio_frame_t'{left: 24'h800001, right: 24'h7FFFFF});
        pushq.push_back(audio_frame_t'{left: 24'h123456, right: 24'h654321});
        repeat (3) @(negedge clock_16_934_400);
        check_reset("reset");
        reset_l = 1'b1;
        cyc     = 0;
        repeat (10 * FRAME + 240) step(0);

        #2 reset_l = 1'b0;
        #1 check_reset("async_reset");
        sample_valid = 1'b0;
        if (busy) begin
            pushq.delete(0);
            busy = 1'b0;
        end
        repeat (2) @(negedge clock_16_934_400);
        check_reset("reset_hold");
        reset_l = 1'b1;
        m_full  = 1'b0;
        m_und   = 1'b0;
        m_tx    = '0;
        cyc     = 0;
        repeat (4 * FRAME) step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Audio output stage that sits directly downstream of the synthesis core. It accepts one stereo sample per frame through a valid/ready handshake and serialises it as a standard Philips I²S stream (BCLK = 64·fs, LRCLK = fs) for the external DAC. It also emits the per-frame `sample_request` strobe that paces upstream sample generation, replacing the ad-hoc 44.1 kHz divider in the top level.

## Interface
Parameters:
- `SAMPLE_WIDTH`, default `CONFIG::AUDIO_BIT_WIDTH` (24): bits per channel sample, two's complement. Must be ≤ `SLOT_WIDTH`-1.
- `SLOT_WIDTH`, default 32: BCLK periods per channel slot.
- `MCLK_PER_BCLK`, default 6: clock cycles per BCLK period. Must be even. 16.9344 MHz / (6·64) = 44.1 kHz.

Ports:
- `clock_16_934_400` in 1: audio master clock. Already decided.
- `reset_l` in 1: asynchronous, active-low reset. Already decided.
- `sample_left` in `SAMPLE_WIDTH`: left sample.
- `sample_right` in `SAMPLE_WIDTH`: right sample.
- `sample_valid` in 1: the left/right pair is valid.
- `sample_ready` out 1: the holding register is empty.
- `sample_request` out 1: one-cycle pulse at the start of each frame.
- `underrun` out 1: one-cycle pulse when a frame starts with no sample available.
- `i2s_bclk` out 1: bit clock.
- `i2s_lrclk` out 1: word select. 0 = left, 1 = right.
- `i2s_sdata` out 1: serial data, MSB first.

## Operation
- Counters:
  - `div` counts 0..`MCLK_PER_BCLK`-1.
  - `bit` counts 0..2·`SLOT_WIDTH`-1 and advances when `div` wraps.
  - One frame is 384 cycles.
- Holding register:
  - Single entry with a `full` flag.
  - `sample_ready` = !`full`.
  - A transfer occurs when `sample_valid` && `sample_ready`. It captures both channels and sets `full`.
  - Upstream holds `sample_left`/`sample_right` stable while `sample_valid` is high and not yet accepted.
- Frame tick: the cycle where `div` = max and `bit` = max.
  - If `full`: load both channels into the 2·`SLOT_WIDTH` shift frame and clear `full`.
  - If not `full`: pulse `underrun` next cycle and load the underrun pattern (see Configuration).
  - A sample accepted in the frame-tick cycle itself is not used for this frame. It stays held for the next frame, and this frame counts as an underrun.
- Slot format (Philips I²S):
  - In slot bit `k` (0-based from the LRCLK edge), bit 0 is always 0.
  - Bits 1..`SAMPLE_WIDTH` carry the sample MSB→LSB.
  - Remaining bits are 0.
- `sample_request` pulses in the first cycle of every frame (`div`=0, `bit`=0), one cycle after the frame tick.
- Reset asserted mid-frame aborts the frame immediately. All state returns to reset values and the held sample is discarded.

## Timing
- All outputs are registered.
- Reset values:
  - `i2s_bclk`, `i2s_lrclk`, `i2s_sdata`, `sample_request` and `underrun` are 0.
  - `sample_ready` is 1.
  - The counters and the shift frame are 0.
- `i2s_bclk` is low for `div` 0..`MCLK_PER_BCLK`/2-1 and high for the rest of the period.
- `i2s_sdata` and `i2s_lrclk` change only in the cycle where BCLK falls (`div`=0). They are stable for `MCLK_PER_BCLK`/2 cycles before and after each BCLK rise.
- `i2s_lrclk` is 0 for `bit` 0..`SLOT_WIDTH`-1 and 1 for the rest of the frame.
- Latency: a sample accepted at any cycle of frame N, except its frame-tick cycle, starts driving on `i2s_sdata` (MSB) at `bit` 1 of frame N+1.
- The first frame after reset transmits zeros. Its frame tick consumes whatever was pushed during it.

## Configuration
- `I2S_UNDERRUN_HOLD_EN`:
  - Defined: on underrun, retransmit the last successfully loaded left/right pair (zeros if none since reset).
  - Undefined: on underrun, transmit zeros in both slots.
- `underrun` pulses in both cases.

## Structure
- `CONFIG` package holds:
  - `AUDIO_CLOCK` and `AUDIO_SAMPLE_RATE`.
  - `I2S_SLOT_WIDTH`, and `I2S_MCLK_PER_BCLK` derived as `AUDIO_CLOCK`/(`AUDIO_SAMPLE_RATE`·2·`I2S_SLOT_WIDTH`).
  - `audio_frame_t` (packed struct {left, right}).
- Sub-module `i2s_frame_timer` owns `div`/`bit`. It outputs `bclk_fall`, `bclk`, `lrclk`, `frame_tick` and `slot_bit`. The parent owns the handshake and the shift frame.

## Test plan
- Reset: hold `reset_l` low, then release. All outputs are 0 except `sample_ready`=1. The first `sample_request` arrives exactly 384 cycles after release.
- Framing: free-run 3 frames. `i2s_bclk` period is 6 cycles (3 low, 3 high). `i2s_lrclk` period is 384 cycles, with 192 cycles low. `sample_request` spacing is 384 cycles.
- Data: push L=0x800001, R=0x7FFFFF during frame 0. Sample `i2s_sdata` on BCLK rises in frame 1:
  - Left slot: 0, then 1,0×22,1, then 0×7.
  - Right slot: 0, then 0,1×23, then 0×7.
- Backpressure: push A, then B immediately. `sample_ready` drops after A and B stalls until the cycle after the frame tick. A transmits in frame 1 and B in frame 2.
- Underrun: skip one push after sending 0x123456/0x654321. `underrun` pulses once. The next frame is zeros (macro undefined) or a repeat of 0x123456/0x654321 (macro defined).
- Mid-frame reset: assert `reset_l` at `bit`=40. All outputs are 0 asynchronously and the held sample is discarded. After release, timing restarts as in the Reset scenario.
